mips_fetch_queue: RTL and testbench
===================================

Name: mips_fetch_queue

Overview:
- Parametrised fetch stage for the pipelined MIPS core; sits between the instruction-memory port and the decode pipeline register.
- Replaces the single-cycle, always-ready pcF/instrF link with:
  - a req/ack handshake that tolerates variable memory latency;
  - a DEPTH-entry prefetch FIFO;
  - decode-side stall;
  - redirect (branch/jump) flush, including discard of an in-flight fetch.

Parameters:
- XLEN, 32, instruction and address width.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous reset, active-low; block is in reset while reset=0.
- pcF  out  XLEN  fetch address to instruction memory.
- reqF  out  1  fetch request; pcF stable while reqF=1 and ackF=0.
- ackF  in  1  memory response; instrF valid in the same cycle.
- instrF  in  XLEN  fetched instruction.
- instrD  out  XLEN  instruction at FIFO head.
- pcplus4D  out  XLEN  address of the head instruction +4.
- validD  out  1  head entry valid.
- stallD  in  1  decode not ready; head is held.
- redirectD  in  1  branch/jump taken in decode; flush the queue.
- targetD  in  XLEN  redirect address.
- countQ  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (reset=0, async), all outputs and state forced:
  - pcF=RESET_PC, reqF=0, validD=0, instrD=0, pcplus4D=0, countQ=0;
  - FSM=F_IDLE; read/write pointers = 0.
- Reset asserted mid-transaction:
  - aborts everything immediately;
  - any ackF while reset=0 is ignored.
- FSM states:
  - F_IDLE: reqF=0. Go to F_REQ when countQ<DEPTH. After reset release, the first request is asserted one cycle later.
  - F_REQ: reqF=1 at pcF. On ackF:
    - push {instrF, pcF+4};
    - pcF←pcF+4;
    - stay in F_REQ if next-cycle occupancy <DEPTH, else go to F_IDLE.
  - F_DROP: reqF=1 at the stale pcF until ackF. On ackF:
    - discard instrF;
    - pcF←saved target;
    - go to F_REQ.
- Handshake rules:
  - at most one outstanding request;
  - a request is issued only when a slot is free, so a push never overflows;
  - ackF may arrive in the same cycle reqF first rises (zero-wait memory), giving 1 instruction/cycle sustained;
  - ackF while reqF=0 is ignored.
- Pop: occurs when validD=1 and stallD=0. The head advances at the clock edge.
- Simultaneous push+pop: countQ unchanged, both pointers advance. Push when full is impossible by construction.
- Latency:
  - memory ack at cycle N → entry visible at validD/instrD in cycle N+1 (registered FIFO);
  - FIFO empty → validD=0, instrD holds its last value.
- Redirect (redirectD=1) has priority over push, pop and stall in the same cycle:
  - FIFO cleared: countQ←0, pointers←0, validD←0 next cycle.
  - If no request is outstanding (F_IDLE, or F_REQ with ackF=1 this cycle): pcF←targetD, FSM→F_REQ.
  - If a request is outstanding (F_REQ with ackF=0): targetD saved, FSM→F_DROP.
  - Redirect while already in F_DROP: the saved target is overwritten with the newest targetD.
- Arithmetic: pcF+4 wraps modulo 2^XLEN (0xFFFF_FFFC→0x0000_0000). Pointers wrap modulo DEPTH.

Optional Feature:
- MIPS_FQ_BYPASS_EN defined:
  - when the FIFO is empty, FSM is F_REQ, ackF=1, stallD=0 and redirectD=0, then instrF/pcF+4 drive instrD/pcplus4D combinationally with validD=1 in the same cycle;
  - that entry is not written to the FIFO;
  - ack→decode latency becomes 0 cycles.
- MIPS_FQ_BYPASS_EN undefined: all outputs are registered as described above; latency 1 cycle.

Test Plan:
- Reset then zero-wait memory (ackF=reqF), stallD=0, RESET_PC=0 → pcF sequence 0,4,8,…; validD high from cycle 2; pcplus4D=4,8,12 in order; countQ≤1.
- Memory latency 3 cycles per ack → pcF held stable 3 cycles per request; each instruction appears one cycle after its ack; no duplicated or lost entries.
- stallD=1 held with DEPTH=4 → countQ reaches 4; reqF drops to 0; instrD stays pinned to the pc=0 word; releasing stallD drains 4 entries in 4 cycles, then fetching resumes at pc=16.
- redirectD=1, targetD=0x100 while idle with countQ=3 → countQ=0 and validD=0 next cycle; pcF=0x100 with reqF=1.
- Redirect to 0x200 while a fetch of 0x40 is outstanding (ack arrives 2 cycles later) → reqF stays on 0x40 until ack; that instruction is never seen at validD; next request is pcF=0x200. A second redirect to 0x300 during F_DROP → next request is 0x300.
- Assert reset=0 mid-request with countQ=2, then release → all outputs back at reset values; first request at RESET_PC; a late ackF during reset produces no entry.

Source files
------------

// File: rtl/mips_fetch_queue.sv
// Fetch stage with req/ack memory handshake and a DEPTH-entry prefetch FIFO.
// Optional MIPS_FQ_BYPASS_EN: a zero-latency path from memory to decode when the FIFO is empty.
module mips_fetch_queue #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [XLEN-1:0]          pcF,
  output logic                     reqF,
  input  logic                     ackF,
  input  logic [XLEN-1:0]          instrF,
  output logic [XLEN-1:0]          instrD,
  output logic [XLEN-1:0]          pcplus4D,
  output logic                     validD,
  input  logic                     stallD,
  input  logic                     redirectD,
  input  logic [XLEN-1:0]          targetD,
  output logic [$clog2(DEPTH):0]   countQ
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {F_IDLE, F_REQ, F_DROP} state_t;

  state_t          state, stateNext;
  logic [XLEN-1:0] pcQ, pcNext, savedQ, savedNext;
  logic [XLEN-1:0] pcPlus4;
  logic [XLEN-1:0] memInstr [DEPTH];
  logic [XLEN-1:0] memPc4 [DEPTH];
  logic [PW-1:0]   rdPtr, wrPtr, rdNext, wrNext;
  logic [CW-1:0]   cntQ, cntNext, remain;
  logic [XLEN-1:0] headInstr, headPc4;
  logic [XLEN-1:0] headInstrNext, headPc4Next;
  logic            push, pop, byp;

  assign pcPlus4 = pcQ + XLEN'(4);

`ifdef MIPS_FQ_BYPASS_EN
  assign byp = (cntQ == '0) && (state == F_REQ) && ackF
               && !stallD && !redirectD;
`else
  assign byp = 1'b0;
`endif

  assign push = (state == F_REQ) && ackF && !redirectD && !byp;
  assign pop  = (cntQ != '0) && !stallD && !redirectD;

  always_comb begin
    cntNext = cntQ + CW'(push) - CW'(pop);
    rdNext  = rdPtr + PW'(pop);
    wrNext  = wrPtr + PW'(push);
    if (redirectD) begin
      cntNext = '0;
      rdNext  = '0;
      wrNext  = '0;
    end
  end

  // Head register keeps its last value when the queue drains.
  always_comb begin
    remain        = cntQ - CW'(pop);
    headInstrNext = headInstr;
    headPc4Next   = headPc4;
    if (!redirectD) begin
      if (remain != '0) begin
        headInstrNext = memInstr[rdNext];
        headPc4Next   = memPc4[rdNext];
      end else if (push || byp) begin
        headInstrNext = instrF;
        headPc4Next   = pcPlus4;
      end
    end
  end

  always_comb begin
    stateNext = state;
    pcNext    = pcQ;
    savedNext = savedQ;
    if (redirectD) begin
      if (state == F_IDLE || ackF) begin
        pcNext    = targetD;
        stateNext = F_REQ;
      end else begin
        savedNext = targetD;
        stateNext = F_DROP;
      end
    end else begin
      unique case (state)
        F_IDLE: begin
          if (cntQ < CW'(DEPTH)) stateNext = F_REQ;
        end
        F_REQ: begin
          if (ackF) begin
            pcNext    = pcPlus4;
            stateNext = (cntNext < CW'(DEPTH)) ? F_REQ : F_IDLE;
          end
        end
        F_DROP: begin
          if (ackF) begin
            pcNext    = savedQ;
            stateNext = F_REQ;
          end
        end
        default: stateNext = F_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= F_IDLE;
      pcQ       <= RESET_PC;
      savedQ    <= '0;
      rdPtr     <= '0;
      wrPtr     <= '0;
      cntQ      <= '0;
      headInstr <= '0;
      headPc4   <= '0;
    end else begin
      state     <= stateNext;
      pcQ       <= pcNext;
      savedQ    <= savedNext;
      rdPtr     <= rdNext;
      wrPtr     <= wrNext;
      cntQ      <= cntNext;
      headInstr <= headInstrNext;
      headPc4   <= headPc4Next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      memInstr[wrPtr] <= instrF;
      memPc4[wrPtr]   <= pcPlus4;
    end
  end

  assign pcF    = pcQ;
  assign reqF   = (state != F_IDLE);
  assign countQ = cntQ;

`ifdef MIPS_FQ_BYPASS_EN
  assign instrD   = byp ? instrF : headInstr;
  assign pcplus4D = byp ? pcPlus4 : headPc4;
  assign validD   = (cntQ != '0) || byp;
`else
  assign instrD   = headInstr;
  assign pcplus4D = headPc4;
  assign validD   = (cntQ != '0);
`endif

endmodule

// File: tb/tb_mips_fetch_queue.sv
// Directed bench for mips_fetch_queue with a simple latency-configurable memory.
module tb_mips_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pcF;
  logic        reqF;
  logic        ackF;
  logic [31:0] instrF;
  logic [31:0] instrD;
  logic [31:0] pcplus4D;
  logic        validD;
  logic        stallD;
  logic        redirectD;
  logic [31:0] targetD;
  logic [2:0]  countQ;

  int cmpCnt = 0;
  int errCnt = 0;

  logic memEn;
  logic forceAck;
  int   latency;
  int   waitCnt = 0;

  always #5 clk = ~clk;

  // Memory returns the bitwise inverse of the address.
  assign instrF = ~pcF;
  assign ackF = forceAck | (memEn & reqF & (waitCnt == latency - 1));

  always @(posedge clk) begin
    if (!reqF || ackF || !memEn) waitCnt <= 0;
    else waitCnt <= waitCnt + 1;
  end

  mips_fetch_queue dut (
    .clk(clk), .reset(reset),
    .pcF(pcF), .reqF(reqF), .ackF(ackF), .instrF(instrF),
    .instrD(instrD), .pcplus4D(pcplus4D), .validD(validD),
    .stallD(stallD), .redirectD(redirectD), .targetD(targetD),
    .countQ(countQ)
  );

  task automatic doReset();
    reset = 1'b0;
    stallD = 1'b0;
    redirectD = 1'b0;
    targetD = '0;
    memEn = 1'b1;
    forceAck = 1'b0;
    latency = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    doReset();
    cmpCnt++; if (pcF !== 32'h0) begin errCnt++; $display("FAIL rst_pcF got %h want %h", pcF, 32'h0); end
    cmpCnt++; if (reqF !== 1'b0) begin errCnt++; $display("FAIL rst_reqF got %b want 0", reqF); end
    cmpCnt++; if (validD !== 1'b0) begin errCnt++; $display("FAIL rst_validD got %b want 0", validD); end
    cmpCnt++; if (instrD !== 32'h0) begin errCnt++; $display("FAIL rst_instrD got %h want 0", instrD); end
    cmpCnt++; if (pcplus4D !== 32'h0) begin errCnt++; $display("FAIL rst_pc4 got %h want 0", pcplus4D); end
    cmpCnt++; if (countQ !== 3'd0) begin errCnt++; $display("FAIL rst_count got %0d want 0", countQ); end
  endtask

  task automatic test_zero_wait();
    doReset();
    reset = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) begin
        cmpCnt++; if (reqF !== 1'b1) begin errCnt++; $display("FAIL zw_req1 got %b want 1", reqF); end
        cmpCnt++; if (pcF !== 32'h0) begin errCnt++; $display("FAIL zw_pc1 got %h want 0", pcF); end
        cmpCnt++; if (validD !== 1'b0) begin errCnt++; $display("FAIL zw_valid1 got %b want 0", validD); end
      end else begin
        cmpCnt++; if (pcF !== 32'(4 * (c - 1))) begin errCnt++; $display("FAIL zw_pc c=%0d got %h want %h", c, pcF, 32'(4 * (c - 1))); end
        cmpCnt++; if (validD !== 1'b1) begin errCnt++; $display("FAIL zw_valid c=%0d got %b want 1", c, validD); end
        cmpCnt++; if (pcplus4D !== 32'(4 * (c - 1))) begin errCnt++; $display("FAIL zw_pc4 c=%0d got %h want %h", c, pcplus4D, 32'(4 * (c - 1))); end
        cmpCnt++; if (instrD !== ~32'(4 * (c - 2))) begin errCnt++; $display("FAIL zw_instr c=%0d got %h want %h", c, instrD, ~32'(4 * (c - 2))); end
        cmpCnt++; if (countQ !== 3'd1) begin errCnt++; $display("FAIL zw_count c=%0d got %0d want 1", c, countQ); end
      end
    end
  endtask

  task automatic test_latency();
    int p;
    doReset();
    latency = 3;
    reset = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      p = (c - 1) / 3;
      cmpCnt++; if (pcF !== 32'(4 * p)) begin errCnt++; $display("FAIL lat_pc c=%0d got %h want %h", c, pcF, 32'(4 * p)); end
      cmpCnt++; if (reqF !== 1'b1) begin errCnt++; $display("FAIL lat_req c=%0d got %b want 1", c, reqF); end
      cmpCnt++; if (validD !== (c >= 4 && (c - 1) % 3 == 0)) begin errCnt++; $display("FAIL lat_valid c=%0d got %b", c, validD); end
      if (c >= 4) begin
        cmpCnt++; if (instrD !== ~32'(4 * (p - 1))) begin errCnt++; $display("FAIL lat_instr c=%0d got %h want %h", c, instrD, ~32'(4 * (p - 1))); end
        cmpCnt++; if (pcplus4D !== 32'(4 * p)) begin errCnt++; $display("FAIL lat_pc4 c=%0d got %h want %h", c, pcplus4D, 32'(4 * p)); end
      end
    end
  endtask

  task automatic test_stall();
    doReset();
    stallD = 1'b1;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    cmpCnt++; if (countQ !== 3'd4) begin errCnt++; $display("FAIL st_full got %0d want 4", countQ); end
    cmpCnt++; if (reqF !== 1'b0) begin errCnt++; $display("FAIL st_req got %b want 0", reqF); end
    cmpCnt++; if (pcF !== 32'h10) begin errCnt++; $display("FAIL st_pc got %h want 10", pcF); end
    @(negedge clk);
    cmpCnt++; if (instrD !== ~32'h0) begin errCnt++; $display("FAIL st_pin got %h want %h", instrD, ~32'h0); end
    stallD = 1'b0;
    for (int c = 6; c <= 10; c++) begin
      if (c > 6) @(negedge clk);
      cmpCnt++; if (instrD !== ~32'(4 * (c - 6))) begin errCnt++; $display("FAIL st_drain c=%0d got %h want %h", c, instrD, ~32'(4 * (c - 6))); end
      cmpCnt++; if (validD !== 1'b1) begin errCnt++; $display("FAIL st_valid c=%0d got %b want 1", c, validD); end
      if (c == 7) begin
        cmpCnt++; if (reqF !== 1'b0) begin errCnt++; $display("FAIL st_req7 got %b want 0", reqF); end
      end
      if (c == 8) begin
        cmpCnt++; if (reqF !== 1'b1 || pcF !== 32'h10) begin errCnt++; $display("FAIL st_resume got %b/%h want 1/10", reqF, pcF); end
      end
    end
  endtask

  task automatic test_redirect_idle();
    doReset();
    stallD = 1'b1;
    reset = 1'b1;
    repeat (6) @(negedge clk);
    stallD = 1'b0;
    @(negedge clk);
    cmpCnt++; if (countQ !== 3'd3 || reqF !== 1'b0) begin errCnt++; $display("FAIL ri_pre got %0d/%b want 3/0", countQ, reqF); end
    stallD = 1'b1;
    redirectD = 1'b1;
    targetD = 32'h100;
    @(negedge clk);
    redirectD = 1'b0;
    cmpCnt++; if (countQ !== 3'd0) begin errCnt++; $display("FAIL ri_count got %0d want 0", countQ); end
    cmpCnt++; if (validD !== 1'b0) begin errCnt++; $display("FAIL ri_valid got %b want 0", validD); end
    cmpCnt++; if (pcF !== 32'h100 || reqF !== 1'b1) begin errCnt++; $display("FAIL ri_pc got %h/%b want 100/1", pcF, reqF); end
    @(negedge clk);
    cmpCnt++; if (validD !== 1'b1 || instrD !== ~32'h100 || pcplus4D !== 32'h104) begin errCnt++; $display("FAIL ri_first got %b/%h/%h", validD, instrD, pcplus4D); end
  endtask

  task automatic test_redirect_drop();
    doReset();
    memEn = 1'b0;
    redirectD = 1'b1;
    targetD = 32'h40;
    reset = 1'b1;
    @(negedge clk);
    targetD = 32'h200;
    cmpCnt++; if (pcF !== 32'h40 || reqF !== 1'b1) begin errCnt++; $display("FAIL rd_c1 got %h/%b want 40/1", pcF, reqF); end
    @(negedge clk);
    redirectD = 1'b0;
    cmpCnt++; if (pcF !== 32'h40 || reqF !== 1'b1) begin errCnt++; $display("FAIL rd_hold2 got %h/%b want 40/1", pcF, reqF); end
    @(negedge clk);
    cmpCnt++; if (pcF !== 32'h40 || validD !== 1'b0) begin errCnt++; $display("FAIL rd_hold3 got %h/%b want 40/0", pcF, validD); end
    forceAck = 1'b1;
    @(negedge clk);
    forceAck = 1'b0;
    cmpCnt++; if (pcF !== 32'h200 || reqF !== 1'b1) begin errCnt++; $display("FAIL rd_new got %h/%b want 200/1", pcF, reqF); end
    cmpCnt++; if (validD !== 1'b0 || countQ !== 3'd0) begin errCnt++; $display("FAIL rd_discard got %b/%0d want 0/0", validD, countQ); end
    redirectD = 1'b1;
    targetD = 32'h280;
    @(negedge clk);
    targetD = 32'h300;
    @(negedge clk);
    redirectD = 1'b0;
    cmpCnt++; if (pcF !== 32'h200 || reqF !== 1'b1) begin errCnt++; $display("FAIL rd_stale got %h/%b want 200/1", pcF, reqF); end
    forceAck = 1'b1;
    @(negedge clk);
    forceAck = 1'b0;
    cmpCnt++; if (pcF !== 32'h300 || validD !== 1'b0) begin errCnt++; $display("FAIL rd_second got %h/%b want 300/0", pcF, validD); end
    memEn = 1'b1;
    @(negedge clk);
    cmpCnt++; if (validD !== 1'b1 || instrD !== ~32'h300 || pcplus4D !== 32'h304) begin errCnt++; $display("FAIL rd_first got %b/%h/%h", validD, instrD, pcplus4D); end
  endtask

  task automatic test_reset_mid();
    doReset();
    stallD = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    memEn = 1'b0;
    cmpCnt++; if (countQ !== 3'd2) begin errCnt++; $display("FAIL rm_pre got %0d want 2", countQ); end
    @(negedge clk);
    reset = 1'b0;
    forceAck = 1'b1;
    #1;
    cmpCnt++; if (pcF !== 32'h0 || reqF !== 1'b0) begin errCnt++; $display("FAIL rm_async got %h/%b want 0/0", pcF, reqF); end
    cmpCnt++; if (countQ !== 3'd0 || validD !== 1'b0) begin errCnt++; $display("FAIL rm_fifo got %0d/%b want 0/0", countQ, validD); end
    cmpCnt++; if (instrD !== 32'h0 || pcplus4D !== 32'h0) begin errCnt++; $display("FAIL rm_head got %h/%h want 0/0", instrD, pcplus4D); end
    repeat (2) @(negedge clk);
    forceAck = 1'b0;
    memEn = 1'b1;
    stallD = 1'b0;
    cmpCnt++; if (countQ !== 3'd0 || validD !== 1'b0) begin errCnt++; $display("FAIL rm_late got %0d/%b want 0/0", countQ, validD); end
    reset = 1'b1;
    @(negedge clk);
    cmpCnt++; if (reqF !== 1'b1 || pcF !== 32'h0 || countQ !== 3'd0) begin errCnt++; $display("FAIL rm_req got %b/%h/%0d", reqF, pcF, countQ); end
    @(negedge clk);
    cmpCnt++; if (validD !== 1'b1 || pcplus4D !== 32'h4) begin errCnt++; $display("FAIL rm_first got %b/%h want 1/4", validD, pcplus4D); end
  endtask

  task automatic test_wrap();
    doReset();
    redirectD = 1'b1;
    targetD = 32'hFFFF_FFFC;
    reset = 1'b1;
    @(negedge clk);
    redirectD = 1'b0;
    cmpCnt++; if (pcF !== 32'hFFFF_FFFC) begin errCnt++; $display("FAIL wr_pc got %h want fffffffc", pcF); end
    @(negedge clk);
    cmpCnt++; if (pcF !== 32'h0) begin errCnt++; $display("FAIL wr_next got %h want 0", pcF); end
    cmpCnt++; if (validD !== 1'b1 || pcplus4D !== 32'h0 || instrD !== 32'h3) begin errCnt++; $display("FAIL wr_head got %b/%h/%h want 1/0/3", validD, pcplus4D, instrD); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_latency();
    test_stall();
    test_redirect_idle();
    test_redirect_drop();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
    $finish;
  end

endmodule
